// File: rtl/dq_delay_line_pkg.sv
// Shared types and constants for the DQ delay line and its FLOATB converter.
package dq_delay_line_pkg;

  localparam int unsigned DQ_W   = 16;
  localparam int unsigned DQN_W  = 11;
  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MANT_W = 6;
  localparam int unsigned PTR_W  = 3;

  // dqn field positions: {sign, exp[3:0], mant[5:0]}
  localparam int unsigned SIGN_BIT = 10;
  localparam int unsigned EXP_MSB  = 9;
  localparam int unsigned EXP_LSB  = 6;
  localparam int unsigned MANT_MSB = 5;
  localparam int unsigned MANT_LSB = 0;

  localparam logic [DQN_W-1:0]  DQN_RESET = 11'h020;
  localparam logic [MANT_W-1:0] MANT_ZERO = 6'd32;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

endpackage

// File: rtl/dq_delay_line_floatb.sv
// FLOATB: 16-bit sign-magnitude DQ to 11-bit {sign, exp, mant} float, purely combinational.
module dq_floatb
  import dq_delay_line_pkg::*;
(
  input  logic [DQ_W-1:0]  dq,
  output logic [DQN_W-1:0] dqn_c
);

  logic [DQ_W-2:0]   mag;
  logic [EXP_W-1:0]  exp_c;
  logic [MANT_W-1:0] mant_c;

  assign mag = dq[DQ_W-2:0];

  // Exponent is the leading-one position plus one; zero magnitude gives zero.
  always_comb begin
    exp_c = '0;
    for (int i = 0; i < int'(DQ_W - 1); i++) begin
      if (mag[i]) exp_c = EXP_W'(i + 1);
    end
  end

  // Mantissa keeps the six bits just below and including the leading one.
  always_comb begin
    mant_c = MANT_ZERO;
    if (exp_c != '0) mant_c = MANT_W'({mag, {MANT_W{1'b0}}} >> exp_c);
  end

  // Pack the fields into the dqn word.
  always_comb begin
    dqn_c                    = '0;
    dqn_c[SIGN_BIT]          = dq[DQ_W-1];
    dqn_c[EXP_MSB:EXP_LSB]   = exp_c;
    dqn_c[MANT_MSB:MANT_LSB] = mant_c;
  end

endmodule

// File: rtl/dq_delay_line.sv
// DQ history delay line: converts accepted DQ samples to DQn and streams DQ1..DQ6.
// Optional macro DQDL_PARALLEL_OUT_EN adds the DQ1_6 port exposing all taps.
module dq_delay_line
  import dq_delay_line_pkg::*;
#(
  parameter int unsigned DEPTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_in0,
  input  logic                   scan_in1,
  input  logic                   scan_in2,
  input  logic                   scan_in3,
  input  logic                   scan_in4,
  input  logic                   scan_enable,
  input  logic                   test_mode,
  output logic                   scan_out0,
  output logic                   scan_out1,
  output logic                   scan_out2,
  output logic                   scan_out3,
  output logic                   scan_out4,
  input  logic                   dq_valid,
  input  logic [DQ_W-1:0]        DQ,
  output logic                   busy,
  output logic                   dqn_valid,
  output logic [PTR_W-1:0]       dqn_idx,
  output logic [DQN_W-1:0]       dqn,
  output logic                   done,
`ifdef DQDL_PARALLEL_OUT_EN
  output logic [DEPTH*DQN_W-1:0] DQ1_6,
`endif
  output logic                   overrun
);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DQN_W-1:0]   tap [1:DEPTH];
  logic [DQN_W-1:0]   floatb_c;
  logic [DQN_W-1:0]   dqn_c;
  logic               accept_c;
  logic               overrun_q;

  // Scan chain placeholders until scan insertion stitches the real chains.
  assign scan_out0 = scan_enable & test_mode & scan_in0;
  assign scan_out1 = scan_enable & test_mode & scan_in1;
  assign scan_out2 = scan_enable & test_mode & scan_in2;
  assign scan_out3 = scan_enable & test_mode & scan_in3;
  assign scan_out4 = scan_enable & test_mode & scan_in4;

  assign accept_c = dq_valid && (state_q == IDLE);

  dq_floatb u_floatb (
    .dq    (DQ),
    .dqn_c (floatb_c)
  );

  // State and stream pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: one accept launches DEPTH stream cycles, then back to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (dq_valid) begin
          state_d = STREAM;
          ptr_d   = PTR_W'(1);
        end
      end
      STREAM: begin
        if (ptr_q == PTR_W'(DEPTH)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Tap shift register; new sample enters at tap 1 on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= int'(DEPTH); k++) tap[k] <= DQN_RESET;
    end else if (accept_c) begin
      tap[1] <= floatb_c;
      for (int k = 2; k <= int'(DEPTH); k++) tap[k] <= tap[k-1];
    end
  end

  // Sticky overrun: any strobe that arrives while streaming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun_q <= 1'b0;
    else if (dq_valid && (state_q != IDLE)) overrun_q <= 1'b1;
  end

  // Select the tap addressed by the stream pointer; zero when idle.
  always_comb begin
    dqn_c = '0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (ptr_q == PTR_W'(k)) dqn_c = tap[k];
    end
  end

  assign dqn_valid = (state_q == STREAM);
  assign dqn_idx   = ptr_q;
  assign dqn       = dqn_c;
  assign done      = (state_q == STREAM) && (ptr_q == PTR_W'(DEPTH));
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

`ifdef DQDL_PARALLEL_OUT_EN
  // Expose every tap, tap1 in the low word.
  for (genvar g = 1; g <= int'(DEPTH); g++) begin : g_par
    assign DQ1_6[g*DQN_W-1 -: DQN_W] = tap[g];
  end
`endif

endmodule

// File: tb/tb_dq_delay_line.sv
// Directed bench for dq_delay_line: conversion, history order, overrun, mid-stream reset.
module tb_dq_delay_line;

  logic        clk = 1'b0;
  logic        reset;
  logic        dq_valid;
  logic [15:0] DQ;
  logic        busy, dqn_valid, done, overrun;
  logic [2:0]  dqn_idx;
  logic [10:0] dqn;
  logic        so0, so1, so2, so3, so4;
`ifdef DQDL_PARALLEL_OUT_EN
  logic [65:0] DQ1_6;
`endif

  int total = 0;
  int bad   = 0;
  logic [10:0] mdl [1:6];

  dq_delay_line dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (so0),
    .scan_out1   (so1),
    .scan_out2   (so2),
    .scan_out3   (so3),
    .scan_out4   (so4),
    .dq_valid    (dq_valid),
    .DQ          (DQ),
    .busy        (busy),
    .dqn_valid   (dqn_valid),
    .dqn_idx     (dqn_idx),
    .dqn         (dqn),
    .done        (done),
`ifdef DQDL_PARALLEL_OUT_EN
    .DQ1_6       (DQ1_6),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 1; k <= 6; k++) mdl[k] = 11'h020;
  endtask

  task automatic mdl_push(input logic [10:0] w);
    for (int k = 6; k >= 2; k--) mdl[k] = mdl[k-1];
    mdl[1] = w;
  endtask

  // Called at a negedge while idle: strobe one sample, return in stream cycle 1.
  task automatic pulse(input logic [15:0] d);
    DQ = d;
    dq_valid = 1'b1;
    @(negedge clk);
    dq_valid = 1'b0;
  endtask

  // Check six stream cycles against the model; optionally strobe during cycle inj.
  task automatic stream_check(input string tag, input int inj);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 66'(dqn_valid), 66'(1));
      chk($sformatf("%s_idx%0d", tag, i), 66'(dqn_idx), 66'(i));
      chk($sformatf("%s_dqn%0d", tag, i), 66'(dqn), 66'(mdl[i]));
      chk($sformatf("%s_done%0d", tag, i), 66'(done), 66'(i == 6));
      chk($sformatf("%s_busy%0d", tag, i), 66'(busy), 66'(1));
      if (i == inj) begin
        DQ = 16'h7FFF;
        dq_valid = 1'b1;
      end
      @(negedge clk);
      dq_valid = 1'b0;
    end
    chk({tag, "_idle_valid"}, 66'(dqn_valid), 66'(0));
    chk({tag, "_idle_busy"}, 66'(busy), 66'(0));
    chk({tag, "_idle_dqn"}, 66'(dqn), 66'(0));
    chk({tag, "_idle_idx"}, 66'(dqn_idx), 66'(0));
`ifdef DQDL_PARALLEL_OUT_EN
    chk({tag, "_par"}, DQ1_6, {mdl[6], mdl[5], mdl[4], mdl[3], mdl[2], mdl[1]});
`endif
  endtask

  initial begin
    reset = 1'b0;
    dq_valid = 1'b0;
    DQ = 16'h0000;
    mdl_reset();
    #2;
    chk("rst_busy", 66'(busy), 66'(0));
    chk("rst_valid", 66'(dqn_valid), 66'(0));
    chk("rst_done", 66'(done), 66'(0));
    chk("rst_overrun", 66'(overrun), 66'(0));
    chk("rst_dqn", 66'(dqn), 66'(0));
    chk("rst_idx", 66'(dqn_idx), 66'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Zero sample: every word is +0 (11'h020)
    pulse(16'h0000); mdl_push(11'h020); stream_check("zero", 0);

    // Conversion vectors
    pulse(16'h8005); mdl_push(11'h4E8); stream_check("cv8005", 0);
    pulse(16'h0001); mdl_push(11'h060); stream_check("cv0001", 0);
    pulse(16'h7FFF); mdl_push(11'h3FF); stream_check("cv7fff", 0);
    pulse(16'h8000); mdl_push(11'h420); stream_check("cv8000", 0);

    // Seven back-to-back accepts at minimum spacing A..G
    pulse(16'h0002); mdl_push(11'h0A0); stream_check("A", 0);
    pulse(16'h0003); mdl_push(11'h0B0); stream_check("B", 0);
    pulse(16'h0004); mdl_push(11'h0E0); stream_check("C", 0);
    pulse(16'h8001); mdl_push(11'h460); stream_check("D", 0);
    pulse(16'h0010); mdl_push(11'h160); stream_check("E", 0);
    pulse(16'h0100); mdl_push(11'h260); stream_check("F", 0);
    pulse(16'h4000); mdl_push(11'h3E0); stream_check("G", 0);
    chk("ovr_before", 66'(overrun), 66'(0));

    // Strobe on stream cycle 3 is dropped and sets overrun
    pulse(16'h0001); mdl_push(11'h060); stream_check("ovr", 3);
    chk("ovr_set", 66'(overrun), 66'(1));
    // Strobe on the done cycle is dropped too; history unaffected
    pulse(16'h0002); mdl_push(11'h0A0); stream_check("ovr_next", 6);
    chk("ovr_sticky", 66'(overrun), 66'(1));

    // Reset in stream cycle 4 aborts at once and clears the taps
    pulse(16'h0003); mdl_push(11'h0B0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pre_idx", 66'(dqn_idx), 66'(4));
    chk("mrst_pre_valid", 66'(dqn_valid), 66'(1));
    #2 reset = 1'b0;
    #1;
    chk("mrst_valid", 66'(dqn_valid), 66'(0));
    chk("mrst_busy", 66'(busy), 66'(0));
    chk("mrst_dqn", 66'(dqn), 66'(0));
    chk("mrst_idx", 66'(dqn_idx), 66'(0));
    chk("mrst_overrun", 66'(overrun), 66'(0));
    mdl_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_noresume", 66'(dqn_valid), 66'(0));
    @(negedge clk);
    chk("mrst_noresume2", 66'(busy), 66'(0));

    // Restart after reset; also sets up the parallel-output pattern
    pulse(16'h0001); mdl_push(11'h060); stream_check("post0001", 0);
    pulse(16'h8005); mdl_push(11'h4E8); stream_check("post8005", 0);
`ifdef DQDL_PARALLEL_OUT_EN
    chk("par_fixed", DQ1_6, {11'h020, 11'h020, 11'h020, 11'h020, 11'h060, 11'h4E8});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
